// File: rtl/alu_pkg.sv
// Shared opcode constants and control-state type for the ALU/MDU unit.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_MULU = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// The first iteration is folded into the start cycle so that done is seen in the
// WIDTH-th cycle after start and the result can be registered into DONE on time.
module mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    // hi_q: partial product high half / remainder; lo_q: multiplier / quotient bits
    logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
    logic             is_div_q, busy_q;
    logic [CntW-1:0]  cnt_q;

    logic [WIDTH-1:0] cur_hi, cur_lo, cur_opnd;
    logic             cur_div;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;
    logic [WIDTH:0]   sum, r_shift, diff;

    // Select the step source: fresh operands on start, else the running registers
    always_comb begin
        if (start) begin
            cur_hi   = '0;
            cur_lo   = is_div ? a : b;
            cur_opnd = is_div ? b : a;
            cur_div  = is_div;
        end else begin
            cur_hi   = hi_q;
            cur_lo   = lo_q;
            cur_opnd = opnd_q;
            cur_div  = is_div_q;
        end
    end

    // One radix-2 step of either shift-add multiply or restoring divide
    always_comb begin
        sum     = {1'b0, cur_hi} + {1'b0, cur_opnd};
        r_shift = {cur_hi, cur_lo[WIDTH-1]};
        diff    = r_shift - {1'b0, cur_opnd};
        if (cur_div) begin
            // remainder < divisor keeps diff in range, so bit WIDTH is the borrow
            if (!diff[WIDTH]) begin
                nxt_hi = diff[WIDTH-1:0];
                nxt_lo = {cur_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = r_shift[WIDTH-1:0];
                nxt_lo = {cur_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (cur_lo[0]) begin
                {nxt_hi, nxt_lo} = {sum, cur_lo[WIDTH-1:1]};
            end else begin
                {nxt_hi, nxt_lo} = {1'b0, cur_hi, cur_lo[WIDTH-1:1]};
            end
        end
    end

    assign done = busy_q && (cnt_q == CntW'(WIDTH));
    assign lo   = lo_q;
    assign hi   = hi_q;

    // Iteration registers and bit counter; counter stops at WIDTH, never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else if (start) begin
            hi_q     <= nxt_hi;
            lo_q     <= nxt_lo;
            opnd_q   <= cur_opnd;
            is_div_q <= is_div;
            busy_q   <= 1'b1;
            cnt_q    <= CntW'(1);
        end else if (busy_q) begin
            if (done) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                hi_q  <= nxt_hi;
                lo_q  <= nxt_lo;
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Single-issue ALU with iterative unsigned multiply/divide and a one-cycle result pulse.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       f,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] hi,
    output logic             zero
);

    state_e           state_q;
    logic             out_valid_q, zero_q;
    logic [WIDTH-1:0] y_q, hi_q;
    logic [WIDTH-1:0] alu_y;
    logic             accept, mdu_start, mdu_is_div, mdu_done;
    logic [WIDTH-1:0] mdu_lo, mdu_hi;

    // Held low while reset is asserted even though the state already reads idle
    assign in_ready   = (state_q == StIdle) && rst_n;
    assign accept     = in_valid && in_ready;
    assign mdu_is_div = (f == OP_DIVU);
    assign mdu_start  = accept && ((f == OP_MULU) || ((f == OP_DIVU) && (b != '0)));

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign hi        = hi_q;
    assign zero      = zero_q;

    // Single-cycle ALU result; reserved opcodes give zero
    always_comb begin
        alu_y = '0;
        case (f)
            OP_AND:  alu_y = a & b;
            OP_OR:   alu_y = a | b;
            OP_ADD:  alu_y = a + b;
            OP_SUB:  alu_y = a - b;
            OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_y = '0;
        endcase
    end

    mdu_iter #(
        .WIDTH(WIDTH)
    ) u_mdu (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mdu_start),
        .is_div(mdu_is_div),
        .a     (a),
        .b     (b),
        .done  (mdu_done),
        .lo    (mdu_lo),
        .hi    (mdu_hi)
    );

    // Control FSM with registered result outputs, updated only when entering DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            hi_q        <= '0;
            zero_q      <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (f == OP_MULU) begin
                            state_q <= StMul;
                        end else if ((f == OP_DIVU) && (b != '0)) begin
                            state_q <= StDiv;
                        end else begin
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                            if (f == OP_DIVU) begin
                                // divide by zero: all-ones quotient, dividend as remainder
                                y_q    <= '1;
                                hi_q   <= a;
                                zero_q <= 1'b0;
                            end else begin
                                y_q    <= alu_y;
                                hi_q   <= '0;
                                zero_q <= (alu_y == '0);
                            end
                        end
                    end
                end
                StMul, StDiv: begin
                    if (mdu_done) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                        y_q         <= mdu_lo;
                        hi_q        <= mdu_hi;
                        zero_q      <= (mdu_lo == '0);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed table vectors on a 32-bit instance, reset-abort sequence, and a
// back-to-back random mix on an 8-bit instance against a reference model.
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid32, in_ready32, out_valid32, zero32;
    logic [31:0] a32, b32, y32, hi32;
    logic [3:0]  f32;
    logic        in_valid8, in_ready8, out_valid8, zero8;
    logic [7:0]  a8, b8, y8, hi8;
    logic [3:0]  f8;

    int tests = 0;
    int fails = 0;
    int ov8_cnt = 0;

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .f(f32), .out_valid(out_valid32), .y(y32), .hi(hi32),
        .zero(zero32)
    );

    alu_mdu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .f(f8), .out_valid(out_valid8), .y(y8), .hi(hi8),
        .zero(zero8)
    );

    always @(negedge clk) if (out_valid8) ov8_cnt <= ov8_cnt + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  f;
        logic [31:0] y;
        logic [31:0] hi;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request from a negedge; returns latency (0 on timeout) and the result
    task automatic run32(input logic [31:0] ta, input logic [31:0] tb, input logic [3:0] tf,
                         output int lat, output logic [31:0] ry, output logic [31:0] rh,
                         output logic rz, output logic busy_ok);
        int n;
        n = 0;
        while (!in_ready32 && n < 100) begin
            @(negedge clk);
            n++;
        end
        a32 = ta; b32 = tb; f32 = tf; in_valid32 = 1'b1;
        @(negedge clk);
        // scramble inputs to show they were captured at acceptance
        in_valid32 = 1'b0; a32 = ~ta; b32 = ~tb; f32 = tf ^ 4'h5;
        lat = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            if (in_ready32) busy_ok = 1'b0;
            if (out_valid32) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        ry = y32; rh = hi32; rz = zero32;
    endtask

    function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] v,
                                           input logic [3:0] op);
        logic [7:0]  r8;
        logic [15:0] p;
        case (op)
            4'd0: begin r8 = x & v; model8 = {8'h00, r8}; end
            4'd1: begin r8 = x | v; model8 = {8'h00, r8}; end
            4'd2: begin r8 = x + v; model8 = {8'h00, r8}; end
            4'd6: begin r8 = x - v; model8 = {8'h00, r8}; end
            4'd7: model8 = (x < v) ? 16'h0001 : 16'h0000;
            4'd8: begin p = {8'h00, x} * {8'h00, v}; model8 = p; end
            4'd9: model8 = (v == 8'h00) ? {x, 8'hFF} : {x % v, x / v};
            default: model8 = 16'h0000;
        endcase
    endfunction

    initial begin
        int          lat;
        logic [31:0] ry, rh;
        logic        rz, busy_ok;
        int          ov_seen;
        logic        rdy_ok;
        logic [3:0]  oplist[9];
        logic [7:0]  ra, rb;
        logic [3:0]  rf;
        logic [15:0] exp8;
        int          exp_lat;

        vecs[0]  = '{32'hFF00FF00, 32'h0F0F0F0F, 4'd0, 32'h0F000F00, 32'h0, 1'b0, 1};
        vecs[1]  = '{32'h00000000, 32'h00000000, 4'd1, 32'h00000000, 32'h0, 1'b1, 1};
        vecs[2]  = '{32'hFFFFFFFF, 32'h00000001, 4'd2, 32'h00000000, 32'h0, 1'b1, 1};
        vecs[3]  = '{32'h12345678, 32'h11111111, 4'd2, 32'h23456789, 32'h0, 1'b0, 1};
        vecs[4]  = '{32'h00000005, 32'h00000007, 4'd6, 32'hFFFFFFFE, 32'h0, 1'b0, 1};
        vecs[5]  = '{32'h00000001, 32'hFFFFFFFF, 4'd7, 32'h00000001, 32'h0, 1'b0, 1};
        vecs[6]  = '{32'hFFFFFFFF, 32'h00000001, 4'd7, 32'h00000000, 32'h0, 1'b1, 1};
        vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd8, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33};
        vecs[8]  = '{32'h00012345, 32'h00001000, 4'd8, 32'h12345000, 32'h0, 1'b0, 33};
        vecs[9]  = '{32'h80000000, 32'h00000004, 4'd8, 32'h00000000, 32'h2, 1'b1, 33};
        vecs[10] = '{32'd100, 32'd7, 4'd9, 32'd14, 32'd2, 1'b0, 33};
        vecs[11] = '{32'd9, 32'd0, 4'd9, 32'hFFFFFFFF, 32'd9, 1'b0, 1};
        vecs[12] = '{32'd5, 32'd9, 4'd9, 32'd0, 32'd5, 1'b1, 33};
        vecs[13] = '{32'hFFFFFFFF, 32'd1, 4'd9, 32'hFFFFFFFF, 32'd0, 1'b0, 33};
        vecs[14] = '{32'd1234, 32'd5678, 4'd15, 32'd0, 32'd0, 1'b1, 1};
        vecs[15] = '{32'hFF, 32'hFF, 4'd3, 32'd0, 32'd0, 1'b1, 1};

        rst_n = 1'b0;
        in_valid32 = 1'b0; a32 = '0; b32 = '0; f32 = '0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; f8 = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready32}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid32}, 64'd0);
        check("rst_y", {32'd0, y32}, 64'd0);
        check("rst_hi", {32'd0, hi32}, 64'd0);
        check("rst_zero", {63'd0, zero32}, 64'd1);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", {63'd0, in_ready32}, 64'd1);
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            run32(vecs[i].a, vecs[i].b, vecs[i].f, lat, ry, rh, rz, busy_ok);
            check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_y", i), {32'd0, ry}, {32'd0, vecs[i].y});
            check($sformatf("v%0d_hi", i), {32'd0, rh}, {32'd0, vecs[i].hi});
            check($sformatf("v%0d_zero", i), {63'd0, rz}, {63'd0, vecs[i].z});
            check($sformatf("v%0d_busy", i), {63'd0, busy_ok}, 64'd1);
            @(negedge clk);
            check($sformatf("v%0d_pulse", i), {63'd0, out_valid32}, 64'd0);
            check($sformatf("v%0d_hold", i), {hi32, y32}, {vecs[i].hi, vecs[i].y});
        end

        // Reset in the middle of a multiply
        run32(32'd9, 32'd0, 4'd9, lat, ry, rh, rz, busy_ok);
        @(negedge clk);
        a32 = 32'hFFFFFFFF; b32 = 32'd3; f32 = 4'd8; in_valid32 = 1'b1;
        @(negedge clk);
        in_valid32 = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_hold_y", {32'd0, y32}, 64'hFFFFFFFF);
        check("mid_busy", {63'd0, in_ready32}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("abort_y", {32'd0, y32}, 64'd0);
        check("abort_hi", {32'd0, hi32}, 64'd0);
        check("abort_zero", {63'd0, zero32}, 64'd1);
        check("abort_out_valid", {63'd0, out_valid32}, 64'd0);
        check("abort_in_ready", {63'd0, in_ready32}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_rel_ready", {63'd0, in_ready32}, 64'd1);
        ov_seen = 0;
        rdy_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid32) ov_seen++;
            if (!in_ready32) rdy_ok = 1'b0;
        end
        check("abort_no_pulse", 64'(ov_seen), 64'd0);
        check("abort_idle", {63'd0, rdy_ok}, 64'd1);
        run32(32'd40, 32'd2, 4'd2, lat, ry, rh, rz, busy_ok);
        check("post_abort_lat", 64'(lat), 64'd1);
        check("post_abort_y", {32'd0, ry}, 64'd42);
        @(negedge clk);

        // Back-to-back random mix on the 8-bit instance
        oplist = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd3, 4'd15};
        for (int i = 0; i < 60; i++) begin
            int n;
            n = 0;
            while (!in_ready8 && n < 50) begin
                @(negedge clk);
                n++;
            end
            ra = 8'($urandom);
            rb = (i % 8 == 3) ? 8'd0 : 8'($urandom);
            rf = oplist[$urandom_range(0, 8)];
            a8 = ra; b8 = rb; f8 = rf; in_valid8 = 1'b1;
            exp8 = model8(ra, rb, rf);
            exp_lat = ((rf == 4'd8) || (rf == 4'd9 && rb != 8'd0)) ? 9 : 1;
            lat = 0;
            for (int c = 1; c <= 50; c++) begin
                @(negedge clk);
                if (out_valid8) begin
                    lat = c;
                    break;
                end
            end
            check($sformatf("r%0d_f%0d_lat", i, rf), 64'(lat), 64'(exp_lat));
            check($sformatf("r%0d_f%0d_res a=%0h b=%0h", i, rf, ra, rb),
                  {48'd0, hi8, y8}, {48'd0, exp8});
            check($sformatf("r%0d_zero", i), {63'd0, zero8}, {63'd0, (exp8[7:0] == 8'd0)});
        end
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        check("r_pulse_count", 64'(ov8_cnt), 64'd60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width (legal 8..64, even).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port f  input  4  opcode: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLTU, 8 MULU, 9 DIVU; others reserved.
REQ-009 SHALL have port out_valid  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port y  output  WIDTH  result (low product / quotient for MULU/DIVU).
REQ-011 SHALL have port hi  output  WIDTH  high product (MULU) / remainder (DIVU); 0 for other ops.
REQ-012 SHALL have port zero  output  1  y == 0, valid with out_valid.

Function
REQ-013 Request accepted when in_valid && in_ready; a, b, f captured at acceptance; later input changes ignored.
REQ-014 in_ready = 1 only in IDLE state; deasserted combinationally? No -- registered: in_ready = (state == IDLE).
REQ-015 States: IDLE, MUL, DIV, DONE; IDLE->DONE for ops 0,1,2,6,7 and reserved; IDLE->MUL for 8; IDLE->DIV for 9 with b != 0; IDLE->DONE for 9 with b == 0.
REQ-016 Single-cycle ops: out_valid asserts the cycle after acceptance (latency 1).
REQ-017 ADD/SUB modulo 2^WIDTH, carry/borrow discarded; SLTU unsigned: y = 1 if a < b else 0.
REQ-018 MULU: radix-2 shift-add, one bit per cycle, WIDTH cycles in MUL then DONE; out_valid latency WIDTH+1; {hi,y} = a*b unsigned, 2*WIDTH bits exact.
REQ-019 DIVU: restoring, one bit per cycle, WIDTH cycles in DIV then DONE; latency WIDTH+1; y = a/b, hi = a%b unsigned.
REQ-020 DIVU with b == 0: latency 1; y = all ones, hi = a.
REQ-021 Reserved opcode: latency 1; y = 0, hi = 0, zero = 1.
REQ-022 DONE lasts exactly one cycle with out_valid = 1, then IDLE; new request accepted no earlier than the cycle after out_valid.
REQ-023 y, hi, zero SHALL hold last result until next out_valid; zero computed from final y only.
REQ-024 Iteration counter width clog2(WIDTH)+1; terminates after exactly WIDTH iterations, no wrap-around.
REQ-025 No back-pressure on output; consumer must sample on out_valid.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, in_ready 0 while asserted, out_valid 0, y 0, hi 0, zero 1, counter 0, datapath registers 0.
REQ-027 in_ready SHALL be 1 in first cycle after rst_n deasserts.
REQ-028 Reset mid-MUL/DIV SHALL abort the operation with no out_valid produced.

Structure
REQ-029 Shared package alu_pkg SHALL hold opcode constants (OP_AND..OP_DIVU) and the state enum typedef.
REQ-030 Iterative multiply/divide datapath SHALL be one sub-module mdu_iter (start, is_div, a, b -> done, lo, hi); ALU ops and FSM stay in alu_mdu.
REQ-031 Implementation SHALL use no vendor primitives or `*`, `/`, `%` operators on WIDTH-wide data.

Verification
REQ-032 WIDTH=32, ADD a=0xFFFFFFFF b=1 -> out_valid cycle 1, y=0, zero=1, hi=0.
REQ-033 SLTU a=1 b=0xFFFFFFFF -> y=1; SUB a=5 b=7 -> y=0xFFFFFFFE, zero=0.
REQ-034 MULU a=0xFFFFFFFF b=0xFFFFFFFF -> out_valid at cycle 33, hi=0xFFFFFFFE, y=0x00000001; in_ready 0 cycles 1..33.
REQ-035 DIVU a=100 b=7 -> cycle 33, y=14, hi=2; DIVU a=9 b=0 -> cycle 1, y=0xFFFFFFFF, hi=9.
REQ-036 Start MULU, pull rst_n low at cycle 10 -> outputs at reset values immediately, no out_valid, in_ready 1 after release.
REQ-037 WIDTH=8 random back-to-back mix of all opcodes vs reference model -> all results match, one out_valid per accepted request.
